// File: rtl/reorder_buffer.sv
// In-order commit buffer: allocates entries at dispatch, captures CDB results,
// and retires the head entry to the register file, the store path or a flush.
module reorder_buffer #(
    parameter int XLEN           = 32,
    parameter int REG_CNT_WIDTH  = 5,
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      rdy_i,
    input  logic                      stall_i,
    input  logic                      dec_ready_i,
    input  logic [1:0]                dec_kind_i,
    input  logic [REG_CNT_WIDTH-1:0]  dec_rd_i,
    input  logic                      cdb_valid_i,
    input  logic [ROB_SIZE_WIDTH-1:0] cdb_id_i,
    input  logic [XLEN-1:0]           cdb_val_i,
    input  logic                      cdb_mispredict_i,
    input  logic [XLEN-1:0]           cdb_target_i,
    input  logic [ROB_SIZE_WIDTH-1:0] q1_id_i,
    input  logic [ROB_SIZE_WIDTH-1:0] q2_id_i,
    output logic                      q1_ready_o,
    output logic                      q2_ready_o,
    output logic [XLEN-1:0]           q1_val_o,
    output logic [XLEN-1:0]           q2_val_o,
    output logic                      rob_full_o,
    output logic [ROB_SIZE_WIDTH-1:0] rob_head_id_o,
    output logic [ROB_SIZE_WIDTH-1:0] rob_tail_id_o,
    output logic                      rob_rf_enable_o,
    output logic [REG_CNT_WIDTH-1:0]  rob_rf_rd_o,
    output logic [XLEN-1:0]           rob_rf_val_o,
    output logic                      rob_store_commit_o,
    output logic [ROB_SIZE_WIDTH-1:0] rob_store_id_o,
    output logic                      flush_o,
    output logic [XLEN-1:0]           flush_pc_o
);

    localparam int N = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_CNT = (ROB_SIZE_WIDTH+1)'(N);

    localparam logic [1:0] KIND_REG = 2'd0;
    localparam logic [1:0] KIND_BR  = 2'd1;
    localparam logic [1:0] KIND_ST  = 2'd2;

    logic [N-1:0]             busy_q;
    logic [N-1:0]             ready_q;
    logic [N-1:0]             mis_q;
    logic [1:0]               kind_q [N];
    logic [REG_CNT_WIDTH-1:0] rd_q   [N];
    logic [XLEN-1:0]          val_q  [N];
    logic [XLEN-1:0]          tgt_q  [N];

    logic [ROB_SIZE_WIDTH-1:0] head_q, head_d;
    logic [ROB_SIZE_WIDTH-1:0] tail_q, tail_d;
    logic [ROB_SIZE_WIDTH:0]   count_q, count_d;

    logic                      rf_en_q, rf_en_d;
    logic [REG_CNT_WIDTH-1:0]  rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]           rf_val_q, rf_val_d;
    logic                      st_q, st_d;
    logic [ROB_SIZE_WIDTH-1:0] st_id_q, st_id_d;
    logic                      flush_q, flush_d;
    logic [XLEN-1:0]           flush_pc_q, flush_pc_d;

    logic       full;
    logic       disp_en;
    logic       wb_en;
    logic       commit_en;
    logic       mis_commit;
    logic [1:0] dec_kind_n;
    logic       q1_hit;
    logic       q2_hit;

    always_comb begin
        full       = (count_q == FULL_CNT);
        dec_kind_n = (dec_kind_i == 2'd3) ? KIND_REG : dec_kind_i;
        disp_en    = rdy_i & dec_ready_i & ~stall_i & ~full & ~flush_q;
        wb_en      = rdy_i & cdb_valid_i & ~flush_q & busy_q[cdb_id_i];
        commit_en  = rdy_i & busy_q[head_q] & ready_q[head_q] & ~flush_q;
        mis_commit = commit_en & mis_q[head_q] & (kind_q[head_q] == KIND_BR);

        rf_en_d    = 1'b0;
        rf_rd_d    = '0;
        rf_val_d   = '0;
        st_d       = 1'b0;
        st_id_d    = '0;
        flush_d    = 1'b0;
        flush_pc_d = '0;

        if (commit_en) begin
            case (kind_q[head_q])
                KIND_ST: begin
                    st_d    = 1'b1;
                    st_id_d = head_q;
                end
                KIND_BR: begin
                    if (mis_q[head_q]) begin
                        flush_d    = 1'b1;
                        flush_pc_d = tgt_q[head_q];
                    end
                end
                default: begin
                    rf_en_d  = 1'b1;
                    rf_rd_d  = rd_q[head_q];
                    rf_val_d = val_q[head_q];
                end
            endcase
        end

        head_d  = head_q + ROB_SIZE_WIDTH'(commit_en);
        tail_d  = tail_q + ROB_SIZE_WIDTH'(disp_en);
        count_d = count_q + (ROB_SIZE_WIDTH+1)'(disp_en) - (ROB_SIZE_WIDTH+1)'(commit_en);

        // A mispredicted branch squashes everything, including a same-cycle dispatch.
        if (mis_commit) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q     <= '0;
            ready_q    <= '0;
            mis_q      <= '0;
            for (int i = 0; i < N; i++) begin
                kind_q[i] <= '0;
                rd_q[i]   <= '0;
                val_q[i]  <= '0;
                tgt_q[i]  <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            rf_en_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_val_q   <= '0;
            st_q       <= 1'b0;
            st_id_q    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (rdy_i) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            rf_en_q    <= rf_en_d;
            rf_rd_q    <= rf_rd_d;
            rf_val_q   <= rf_val_d;
            st_q       <= st_d;
            st_id_q    <= st_id_d;
            flush_q    <= flush_d;
            flush_pc_q <= flush_pc_d;

            if (mis_commit) begin
                busy_q  <= '0;
                ready_q <= '0;
            end else begin
                if (disp_en) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                    kind_q[tail_q]  <= dec_kind_n;
                    rd_q[tail_q]    <= (dec_kind_n == KIND_REG) ? dec_rd_i : '0;
                end
                if (wb_en) begin
                    ready_q[cdb_id_i] <= 1'b1;
                    val_q[cdb_id_i]   <= cdb_val_i;
                    mis_q[cdb_id_i]   <= cdb_mispredict_i;
                    tgt_q[cdb_id_i]   <= cdb_target_i;
                end
                if (commit_en) begin
                    busy_q[head_q]  <= 1'b0;
                    ready_q[head_q] <= 1'b0;
                end
            end
        end
    end

    // Operand bypass: a result on the CDB this cycle is visible before it is latched.
    always_comb begin
        q1_hit     = cdb_valid_i & ~flush_q & busy_q[cdb_id_i] & (cdb_id_i == q1_id_i);
        q2_hit     = cdb_valid_i & ~flush_q & busy_q[cdb_id_i] & (cdb_id_i == q2_id_i);
        q1_ready_o = q1_hit | (busy_q[q1_id_i] & ready_q[q1_id_i]);
        q2_ready_o = q2_hit | (busy_q[q2_id_i] & ready_q[q2_id_i]);
        q1_val_o   = q1_hit ? cdb_val_i : val_q[q1_id_i];
        q2_val_o   = q2_hit ? cdb_val_i : val_q[q2_id_i];
    end

    assign rob_full_o         = full;
    assign rob_head_id_o      = head_q;
    assign rob_tail_id_o      = tail_q;
    assign rob_rf_enable_o    = rf_en_q;
    assign rob_rf_rd_o        = rf_rd_q;
    assign rob_rf_val_o       = rf_val_q;
    assign rob_store_commit_o = st_q;
    assign rob_store_id_o     = st_id_q;
    assign flush_o            = flush_q;
    assign flush_pc_o         = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: scenario tasks plus a commit scoreboard that
// checks every retirement against the order in which entries were dispatched.
module tb_reorder_buffer;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        stall;
    logic        dec_ready;
    logic [1:0]  dec_kind;
    logic [4:0]  dec_rd;
    logic        cdb_valid;
    logic [2:0]  cdb_id;
    logic [31:0] cdb_val;
    logic        cdb_mispredict;
    logic [31:0] cdb_target;
    logic [2:0]  q1_id, q2_id;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic        rob_full;
    logic [2:0]  rob_head_id, rob_tail_id;
    logic        rob_rf_enable;
    logic [4:0]  rob_rf_rd;
    logic [31:0] rob_rf_val;
    logic        rob_store_commit;
    logic [2:0]  rob_store_id;
    logic        flush;
    logic [31:0] flush_pc;

    reorder_buffer #(.XLEN(32), .REG_CNT_WIDTH(5), .ROB_SIZE_WIDTH(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rdy_i(rdy), .stall_i(stall),
        .dec_ready_i(dec_ready), .dec_kind_i(dec_kind), .dec_rd_i(dec_rd),
        .cdb_valid_i(cdb_valid), .cdb_id_i(cdb_id), .cdb_val_i(cdb_val),
        .cdb_mispredict_i(cdb_mispredict), .cdb_target_i(cdb_target),
        .q1_id_i(q1_id), .q2_id_i(q2_id),
        .q1_ready_o(q1_ready), .q2_ready_o(q2_ready),
        .q1_val_o(q1_val), .q2_val_o(q2_val),
        .rob_full_o(rob_full), .rob_head_id_o(rob_head_id), .rob_tail_id_o(rob_tail_id),
        .rob_rf_enable_o(rob_rf_enable), .rob_rf_rd_o(rob_rf_rd), .rob_rf_val_o(rob_rf_val),
        .rob_store_commit_o(rob_store_commit), .rob_store_id_o(rob_store_id),
        .flush_o(flush), .flush_pc_o(flush_pc)
    );

    localparam logic [1:0] T_RF = 2'd0, T_ST = 2'd1, T_FL = 2'd2;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [2:0]  id;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every visible commit must match the oldest expected retirement.
    always @(negedge clk) begin
        if (rst_n && (rob_rf_enable || rob_store_commit || flush)) begin
            exp_t       e;
            logic [2:0] hm1;
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got rf=%0b st=%0b fl=%0b, want no commit",
                         rob_rf_enable, rob_store_commit, flush);
            end else begin
                e   = sb_q.pop_front();
                hm1 = rob_head_id - 3'd1;
                case (e.typ)
                    T_RF: if (!(rob_rf_enable === 1'b1 && rob_store_commit === 1'b0 && flush === 1'b0 &&
                                rob_rf_rd === e.rd && rob_rf_val === e.val && hm1 === e.id)) begin
                        n_fail++;
                        $display("FAIL sb_rf: got en=%0b rd=%0d val=%h head-1=%0d, want en=1 rd=%0d val=%h head-1=%0d",
                                 rob_rf_enable, rob_rf_rd, rob_rf_val, hm1, e.rd, e.val, e.id);
                    end
                    T_ST: if (!(rob_store_commit === 1'b1 && rob_rf_enable === 1'b0 && flush === 1'b0 &&
                                rob_store_id === e.id && hm1 === e.id)) begin
                        n_fail++;
                        $display("FAIL sb_store: got st=%0b id=%0d head-1=%0d, want st=1 id=%0d",
                                 rob_store_commit, rob_store_id, hm1, e.id);
                    end
                    default: if (!(flush === 1'b1 && rob_rf_enable === 1'b0 && rob_store_commit === 1'b0 &&
                                   flush_pc === e.val && rob_head_id === 3'd0 && rob_tail_id === 3'd0)) begin
                        n_fail++;
                        $display("FAIL sb_flush: got fl=%0b pc=%h rf=%0b head=%0d tail=%0d, want fl=1 pc=%h rf=0 head=0 tail=0",
                                 flush, flush_pc, rob_rf_enable, rob_head_id, rob_tail_id, e.val);
                    end
                endcase
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [1:0] t, input logic [4:0] rd,
                                input logic [31:0] v, input logic [2:0] id);
        exp_t e;
        e.typ = t; e.rd = rd; e.val = v; e.id = id;
        return e;
    endfunction

    task automatic dispatch(input logic [1:0] kind, input logic [4:0] rd, input logic [2:0] exp_id);
        n_cmp++;
        if (rob_tail_id !== exp_id) begin
            n_fail++;
            $display("FAIL dispatch_id: got tail=%0d, want %0d", rob_tail_id, exp_id);
        end
        dec_ready = 1'b1; dec_kind = kind; dec_rd = rd;
        cyc();
        dec_ready = 1'b0;
    endtask

    task automatic cdb(input logic [2:0] id, input logic [31:0] v,
                       input logic mis, input logic [31:0] tgt);
        cdb_valid = 1'b1; cdb_id = id; cdb_val = v; cdb_mispredict = mis; cdb_target = tgt;
        cyc();
        cdb_valid = 1'b0; cdb_mispredict = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() > 0; i++) cyc();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d commits outstanding, want 0", sb_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if ({rob_rf_enable, rob_store_commit, flush, rob_full, rob_head_id, rob_tail_id,
             rob_rf_rd, rob_rf_val, rob_store_id, flush_pc} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rf=%0b st=%0b fl=%0b full=%0b head=%0d tail=%0d, want all 0",
                     rob_rf_enable, rob_store_commit, flush, rob_full, rob_head_id, rob_tail_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_in_order();
        dispatch(2'd0, 5'd1, 3'd0);
        dispatch(2'd0, 5'd2, 3'd1);
        dispatch(2'd0, 5'd3, 3'd2);
        sb_q.push_back(mk(T_RF, 5'd1, 32'h10, 3'd0));
        sb_q.push_back(mk(T_RF, 5'd2, 32'h20, 3'd1));
        sb_q.push_back(mk(T_RF, 5'd3, 32'h30, 3'd2));
        cdb(3'd2, 32'h30, 1'b0, 32'h0);
        cdb(3'd0, 32'h10, 1'b0, 32'h0);
        cdb(3'd1, 32'h20, 1'b0, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            n_cmp++;
            if (rob_rf_enable !== 1'b1 || rob_rf_rd !== 5'(k)) begin
                n_fail++;
                $display("FAIL in_order_seq: got en=%0b rd=%0d, want en=1 rd=%0d", rob_rf_enable, rob_rf_rd, k);
            end
            cyc();
        end
        drain(10);
    endtask

    task automatic test_full();
        test_reset();
        for (int i = 0; i < 8; i++) dispatch(2'd0, 5'(i + 8), 3'(i));
        n_cmp++;
        if (rob_full !== 1'b1 || rob_tail_id !== 3'd0) begin
            n_fail++;
            $display("FAIL full_set: got full=%0b tail=%0d, want full=1 tail=0", rob_full, rob_tail_id);
        end
        dec_ready = 1'b1; dec_kind = 2'd0; dec_rd = 5'd31;
        cyc();
        dec_ready = 1'b0;
        n_cmp++;
        if (rob_full !== 1'b1 || rob_tail_id !== 3'd0) begin
            n_fail++;
            $display("FAIL full_block: got full=%0b tail=%0d, want full=1 tail=0", rob_full, rob_tail_id);
        end
        sb_q.push_back(mk(T_RF, 5'd8, 32'h55, 3'd0));
        cdb(3'd0, 32'h55, 1'b0, 32'h0);
        n_cmp++;
        if (rob_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: got full=%0b, want 1", rob_full);
        end
        cyc();
        n_cmp++;
        if (rob_full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_drop: got full=%0b, want 0", rob_full);
        end
        dispatch(2'd0, 5'd20, 3'd0);
        drain(10);
    endtask

    task automatic test_mispredict();
        test_reset();
        dispatch(2'd1, 5'd0, 3'd0);
        dispatch(2'd0, 5'd5, 3'd1);
        sb_q.push_back(mk(T_FL, 5'd0, 32'h100, 3'd0));
        cdb(3'd1, 32'h77, 1'b0, 32'h0);
        cdb(3'd0, 32'h0, 1'b1, 32'h100);
        cyc();
        n_cmp++;
        if (flush !== 1'b1 || flush_pc !== 32'h100 || rob_rf_enable !== 1'b0 ||
            rob_head_id !== 3'd0 || rob_tail_id !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_pulse: got fl=%0b pc=%h rf=%0b head=%0d tail=%0d, want fl=1 pc=100 rf=0 head=0 tail=0",
                     flush, flush_pc, rob_rf_enable, rob_head_id, rob_tail_id);
        end
        dec_ready = 1'b1; dec_kind = 2'd0; dec_rd = 5'd6;
        cyc();
        dec_ready = 1'b0;
        n_cmp++;
        if (flush !== 1'b0 || rob_rf_enable !== 1'b0 || rob_tail_id !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_after: got fl=%0b rf=%0b tail=%0d, want fl=0 rf=0 tail=0",
                     flush, rob_rf_enable, rob_tail_id);
        end
        drain(5);
    endtask

    task automatic test_store();
        dispatch(2'd2, 5'd0, 3'd0);
        sb_q.push_back(mk(T_ST, 5'd0, 32'h0, 3'd0));
        cdb(3'd0, 32'hDEAD, 1'b0, 32'h0);
        cyc();
        n_cmp++;
        if (rob_store_commit !== 1'b1 || rob_store_id !== 3'd0) begin
            n_fail++;
            $display("FAIL store_pulse: got st=%0b id=%0d, want st=1 id=0", rob_store_commit, rob_store_id);
        end
        cyc();
        n_cmp++;
        if (rob_store_commit !== 1'b0) begin
            n_fail++;
            $display("FAIL store_width: got st=%0b, want 0", rob_store_commit);
        end
        drain(5);
    endtask

    task automatic test_bypass();
        dispatch(2'd0, 5'd7, 3'd1);
        sb_q.push_back(mk(T_RF, 5'd7, 32'hABCD, 3'd1));
        q1_id = 3'd1; q2_id = 3'd1;
        #1;
        n_cmp++;
        if (q1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bypass_pending: got q1_ready=%0b, want 0", q1_ready);
        end
        cdb_valid = 1'b1; cdb_id = 3'd1; cdb_val = 32'hABCD; cdb_mispredict = 1'b0;
        #1;
        n_cmp++;
        if (q1_ready !== 1'b1 || q1_val !== 32'hABCD || q2_ready !== 1'b1 || q2_val !== 32'hABCD) begin
            n_fail++;
            $display("FAIL bypass_same: got q1=%0b/%h q2=%0b/%h, want 1/abcd",
                     q1_ready, q1_val, q2_ready, q2_val);
        end
        cyc();
        cdb_valid = 1'b0;
        #1;
        n_cmp++;
        if (q1_ready !== 1'b1 || q1_val !== 32'hABCD) begin
            n_fail++;
            $display("FAIL lookup_latched: got q1=%0b/%h, want 1/abcd", q1_ready, q1_val);
        end
        drain(5);
    endtask

    task automatic test_reset_mid();
        dispatch(2'd0, 5'd9, 3'd2);
        dispatch(2'd0, 5'd10, 3'd3);
        sb_q.push_back(mk(T_RF, 5'd9, 32'h42, 3'd2));
        cdb(3'd2, 32'h42, 1'b0, 32'h0);
        cyc();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rob_rf_enable !== 1'b0 || rob_rf_val !== 32'h0 || rob_head_id !== 3'd0 || rob_tail_id !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got rf=%0b val=%h head=%0d tail=%0d, want all 0",
                     rob_rf_enable, rob_rf_val, rob_head_id, rob_tail_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        q1_id = 3'd3;
        cdb(3'd3, 32'h99, 1'b0, 32'h0);
        cyc();
        cyc();
        n_cmp++;
        if (q1_ready !== 1'b0 || rob_rf_enable !== 1'b0 || rob_head_id !== 3'd0) begin
            n_fail++;
            $display("FAIL stale_cdb: got q1_ready=%0b rf=%0b head=%0d, want 0 0 0",
                     q1_ready, rob_rf_enable, rob_head_id);
        end
        drain(2);
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; stall = 1'b0;
        dec_ready = 1'b0; dec_kind = 2'd0; dec_rd = 5'd0;
        cdb_valid = 1'b0; cdb_id = 3'd0; cdb_val = 32'h0; cdb_mispredict = 1'b0; cdb_target = 32'h0;
        q1_id = 3'd0; q2_id = 3'd0;
        #12;
        test_reset();
        test_in_order();
        test_full();
        test_mispredict();
        test_store();
        test_bypass();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
